// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter placing producer results onto the common data bus.
//
// Each producer (0 = ALU, 1 = LSB, 2 = branch) hands one result over a valid/ready
// handshake into a private one-entry slot. Every enabled cycle, the first held slot at or
// after the round-robin pointer is broadcast as a registered CDB beat. A flush empties
// every slot.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   rdy        global enable; low freezes all state
//   flush      ROB flush; discards held results, resets the pointer
//   req_valid  per-producer result offer
//   req_dest   per-producer ROB id, slice [i*ROB_ID_WIDTH +: ROB_ID_WIDTH]
//   req_value  per-producer value, slice [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-producer slot can accept this cycle (combinational)
//   cdb_valid  registered broadcast strobe
//   cdb_dest   registered ROB id being completed
//   cdb_value  registered result value
//   cdb_src    registered index of the granted producer
//   busy       at least one slot holds a result (combinational)
module cdb_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned ROB_ID_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ROB_ID_WIDTH-1:0] req_dest,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_value,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            cdb_valid,
  output logic [ROB_ID_WIDTH-1:0]         cdb_dest,
  output logic [DATA_WIDTH-1:0]           cdb_value,
  output logic [1:0]                      cdb_src,
  output logic                            busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]                   slot_valid_q, slot_valid_d;
  logic [NUM_REQ-1:0][ROB_ID_WIDTH-1:0] slot_dest_q, slot_dest_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   slot_value_q, slot_value_d;
  logic [PtrW-1:0]                      ptr_q, ptr_d;
  logic                                 cdb_valid_q, cdb_valid_d;
  logic [ROB_ID_WIDTH-1:0]              cdb_dest_q, cdb_dest_d;
  logic [DATA_WIDTH-1:0]                cdb_value_q, cdb_value_d;
  logic [1:0]                           cdb_src_q, cdb_src_d;

  logic            grant_found;
  logic [PtrW-1:0] grant_idx;
  int unsigned     scan_idx;

  // Ready depends only on the slot being empty, so a granted slot refills next cycle at
  // the earliest.
  assign req_ready = {NUM_REQ{rst && rdy && !flush}} & ~slot_valid_q;
  assign busy      = |slot_valid_q;

  // Scan ptr, ptr+1, ... modulo NUM_REQ for the first held slot.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!grant_found && slot_valid_q[scan_idx[PtrW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_dest_d  = slot_dest_q;
    slot_value_d = slot_value_q;
    ptr_d        = ptr_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_dest_d   = cdb_dest_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    if (rdy) begin
      if (flush) begin
        slot_valid_d = '0;
        cdb_valid_d  = 1'b0;
        cdb_dest_d   = '0;
        ptr_d        = '0;
      end else begin
        if (grant_found) begin
          cdb_valid_d             = 1'b1;
          cdb_dest_d              = slot_dest_q[grant_idx];
          cdb_value_d             = slot_value_q[grant_idx];
          cdb_src_d               = 2'(grant_idx);
          slot_valid_d[grant_idx] = 1'b0;
          ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
        end else begin
          cdb_valid_d = 1'b0;
          cdb_dest_d  = '0;
        end
        // A granted slot is never ready, so accept and grant never touch the same slot.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i] && req_ready[i] &&
              req_dest[i*ROB_ID_WIDTH +: ROB_ID_WIDTH] != '0) begin
            slot_valid_d[i] = 1'b1;
            slot_dest_d[i]  = req_dest[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
            slot_value_d[i] = req_value[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_valid_q <= '0;
      slot_dest_q  <= '0;
      slot_value_q <= '0;
      ptr_q        <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_dest_q   <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_dest_q  <= slot_dest_d;
      slot_value_q <= slot_value_d;
      ptr_q        <= ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_dest_q   <= cdb_dest_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_dest  = cdb_dest_q;
  assign cdb_value = cdb_value_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios with literal expectations plus a
// behavioural model compared against the DUT on every negative clock edge.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic [2:0]  req_valid;
  logic [11:0] req_dest;
  logic [95:0] req_value;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_dest;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  cdb_arbiter #(
    .NUM_REQ     (3),
    .ROB_ID_WIDTH(4),
    .DATA_WIDTH  (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .req_valid(req_valid),
    .req_dest (req_dest),
    .req_value(req_value),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid),
    .cdb_dest (cdb_dest),
    .cdb_value(cdb_value),
    .cdb_src  (cdb_src),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: held results per producer plus the pointer to scan from.
  bit          m_held[3];
  logic [3:0]  m_dest[3];
  logic [31:0] m_val[3];
  int          m_ptr;
  logic        m_cv;
  logic [3:0]  m_cd;
  logic [31:0] m_cval;
  logic [1:0]  m_csrc;

  // Inputs change shortly after posedge, so at negedge they are what the next edge sees:
  // compare the present state first, then advance the model across that next edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] exp_ready;
      for (int i = 0; i < 3; i++) exp_ready[i] = rst && rdy && !flush && !m_held[i];
      chk("m_cdb_valid", cdb_valid, m_cv);
      chk("m_cdb_dest", cdb_dest, m_cd);
      chk("m_cdb_value", cdb_value, m_cval);
      chk("m_cdb_src", cdb_src, m_csrc);
      chk("m_req_ready", req_ready, exp_ready);
      chk("m_busy", busy, m_held[0] || m_held[1] || m_held[2]);
    end
    if (!rst) begin
      for (int i = 0; i < 3; i++) m_held[i] = 0;
      m_ptr = 0; m_cv = 0; m_cd = 0; m_cval = 0; m_csrc = 0;
    end else if (rdy && flush) begin
      for (int i = 0; i < 3; i++) m_held[i] = 0;
      m_ptr = 0; m_cv = 0; m_cd = 0;
    end else if (rdy) begin
      bit take[3];
      int w;
      for (int i = 0; i < 3; i++) take[i] = req_valid[i] && !m_held[i];
      w = -1;
      for (int k = 0; k < 3; k++) begin
        int j;
        j = (m_ptr + k) % 3;
        if (w < 0 && m_held[j]) w = j;
      end
      if (w >= 0) begin
        m_cv = 1; m_cd = m_dest[w]; m_cval = m_val[w]; m_csrc = 2'(w);
        m_held[w] = 0;
        m_ptr = (w + 1) % 3;
      end else begin
        m_cv = 0; m_cd = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (take[i] && req_dest[i*4 +: 4] != 4'd0) begin
          m_held[i] = 1;
          m_dest[i] = req_dest[i*4 +: 4];
          m_val[i]  = req_value[i*32 +: 32];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input int i, input logic [3:0] d, input logic [31:0] v);
    req_valid[i]       = 1'b1;
    req_dest[i*4 +: 4] = d;
    req_value[i*32 +: 32] = v;
  endtask

  task automatic clear_req();
    req_valid = '0;
  endtask

  task automatic beat(input string name, input logic [1:0] src, input logic [3:0] d,
                      input logic [31:0] v);
    chk({name, "_valid"}, cdb_valid, 1'b1);
    chk({name, "_src"}, cdb_src, src);
    chk({name, "_dest"}, cdb_dest, d);
    chk({name, "_value"}, cdb_value, v);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    req_valid = '0; req_dest = '0; req_value = '0;
    step();
    step();
    chk_en = 1;
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_cdb_value", cdb_value, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_ready", req_ready, 3'b111);
    chk("rst_busy", busy, 1'b0);

    // Single request on producer 1.
    offer(1, 4'd5, 32'hDEADBEEF);
    step();
    clear_req();
    step();
    beat("single", 2'd1, 4'd5, 32'hDEADBEEF);
    step();
    chk("single_after", cdb_valid, 1'b0);

    // Flush to bring the pointer back to 0, then all three at once.
    flush = 1'b1;
    step();
    flush = 1'b0;
    offer(0, 4'd1, 32'h11); offer(1, 4'd2, 32'h22); offer(2, 4'd3, 32'h33);
    step();
    clear_req();
    step();
    beat("sim0", 2'd0, 4'd1, 32'h11);
    step();
    beat("sim1", 2'd1, 4'd2, 32'h22);
    step();
    beat("sim2", 2'd2, 4'd3, 32'h33);
    step();
    chk("sim_idle", cdb_valid, 1'b0);

    // Round robin: grant 0 moves ptr to 1, so 2 beats 0 next.
    offer(0, 4'd4, 32'h44);
    step();
    clear_req();
    step();
    beat("rr_first", 2'd0, 4'd4, 32'h44);
    offer(0, 4'd6, 32'h66); offer(2, 4'd7, 32'h77);
    step();
    clear_req();
    step();
    beat("rr_p2", 2'd2, 4'd7, 32'h77);
    step();
    beat("rr_p0", 2'd0, 4'd6, 32'h66);
    step();

    // Backpressure: slot 0 stays full until it is granted.
    offer(0, 4'd8, 32'h88); offer(1, 4'd9, 32'h99);
    step();
    #1;
    chk("bp_ready_full", req_ready, 3'b100);
    offer(1, 4'd10, 32'hAA);
    step();
    beat("bp_p1", 2'd1, 4'd9, 32'h99);
    chk("bp_ready0_low", req_ready[0], 1'b0);
    chk("bp_ready1_high", req_ready[1], 1'b1);
    step();
    beat("bp_p0", 2'd0, 4'd8, 32'h88);
    chk("bp_ready0_high", req_ready[0], 1'b1);
    clear_req();
    step();
    beat("bp_p1b", 2'd1, 4'd10, 32'hAA);

    // Dropped handshake: dest 0 is never held or broadcast.
    offer(2, 4'd0, 32'hBAD);
    step();
    clear_req();
    chk("drop_busy", busy, 1'b0);
    chk("drop_nobeat", cdb_valid, 1'b0);
    step();
    chk("drop_nobeat2", cdb_valid, 1'b0);

    // Flush with every slot full.
    offer(0, 4'd11, 32'hB0); offer(1, 4'd12, 32'hB1); offer(2, 4'd13, 32'hB2);
    step();
    clear_req();
    flush = 1'b1;
    #1;
    chk("flush_busy_before", busy, 1'b1);
    step();
    flush = 1'b0;
    #1;
    chk("flush_cdb", cdb_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_ready", req_ready, 3'b111);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("flush_quiet", cdb_valid, 1'b0);
    end

    // Pointer is 0 after flush; then freeze with a beat on the bus.
    offer(0, 4'd1, 32'h101); offer(1, 4'd2, 32'h102); offer(2, 4'd3, 32'h103);
    step();
    clear_req();
    step();
    beat("post_flush", 2'd0, 4'd1, 32'h101);
    rdy = 1'b0;
    #1;
    chk("hold_ready", req_ready, 3'b000);
    for (int c = 0; c < 3; c++) begin
      step();
      beat("hold", 2'd0, 4'd1, 32'h101);
      chk("hold_busy", busy, 1'b1);
    end
    rdy = 1'b1;
    step();
    beat("resume", 2'd1, 4'd2, 32'h102);

    // Reset mid-stream.
    rst = 1'b0;
    step();
    chk("midrst_valid", cdb_valid, 1'b0);
    chk("midrst_dest", cdb_dest, 4'd0);
    chk("midrst_value", cdb_value, 32'h0);
    chk("midrst_src", cdb_src, 2'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", req_ready, 3'b000);
    rst = 1'b1;
    #1;
    chk("midrst_ready_after", req_ready, 3'b111);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
